// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side prefetch stage.
package fifo_pkg;

    localparam int PREFETCH_DEPTH    = 2;
    localparam int DATA_SIZE_DEFAULT = 8;

    // Occupancy/level encoding: 0..2 fits in two bits.
    typedef logic [1:0] level_t;

    function automatic level_t level_add(input level_t a, input logic b);
        return a + level_t'(b);
    endfunction

endpackage

// File: rtl/prefetch_skid_buf.sv
// Two-entry head/skid buffer: loads, shifts and counts the words held for the stream output.
module prefetch_skid_buf
    import fifo_pkg::*;
#(
    parameter int data_size = DATA_SIZE_DEFAULT
) (
    input  logic                 r_clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [data_size-1:0] din,
    output logic [data_size-1:0] dout,
    output level_t               cnt,
    output logic                 valid
);

    logic [data_size-1:0] buf_reg  [PREFETCH_DEPTH];
    logic [data_size-1:0] buf_next [PREFETCH_DEPTH];
    level_t               cnt_reg;
    level_t               cnt_next;
    logic                 valid_reg;
    logic                 pop_ok;

    // A pop with nothing stored is ignored so cnt can never underflow.
    assign pop_ok = pop && (cnt_reg != 2'd0);

    always_comb begin
        buf_next = buf_reg;
        cnt_next = cnt_reg;
        unique case ({push, pop_ok})
            2'b10: begin
                if (cnt_reg == 2'd0) begin
                    buf_next[0] = din;
                    cnt_next    = 2'd1;
                end else if (cnt_reg == 2'd1) begin
                    buf_next[1] = din;
                    cnt_next    = 2'd2;
                end
            end
            2'b11: begin
                if (cnt_reg == 2'd1) begin
                    buf_next[0] = din;
                end else begin
                    buf_next[0] = buf_reg[1];
                    buf_next[1] = din;
                end
            end
            2'b01: begin
                if (cnt_reg == 2'd2) begin
                    buf_next[0] = buf_reg[1];
                end
                cnt_next = cnt_reg - 2'd1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge r_clk) begin
        if (reset) begin
            for (int i = 0; i < PREFETCH_DEPTH; i++) begin
                buf_reg[i] <= '0;
            end
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            buf_reg   <= buf_next;
            cnt_reg   <= cnt_next;
            valid_reg <= (cnt_next != 2'd0);
        end
    end

    assign dout  = buf_reg[0];
    assign cnt   = cnt_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/fifo_read_prefetch.sv
// Turns the FIFO rd/empty + 1-cycle read data interface into a registered valid/ready stream.
// Optional level/overrun outputs are built when FIFO_PREFETCH_LEVEL_EN is defined.
module fifo_read_prefetch
    import fifo_pkg::*;
#(
    parameter int data_size = DATA_SIZE_DEFAULT,
    parameter int depth     = PREFETCH_DEPTH
) (
    input  logic                 r_clk,
    input  logic                 reset,
    input  logic                 empty,
    output logic                 rd,
    input  logic [data_size-1:0] rd_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [data_size-1:0] m_data
`ifdef FIFO_PREFETCH_LEVEL_EN
    ,
    output logic [1:0]           level,
    output logic                 overrun
`endif
);

    if (depth != PREFETCH_DEPTH) begin : g_depth_check
        $error("fifo_read_prefetch: depth must be 2");
    end

    level_t     cnt;
    logic       inflight_reg;
    logic       pop;
    logic       push;
    logic [2:0] credit_used;

    assign pop  = m_valid && m_ready;
    assign push = inflight_reg;

    // Words stored plus the one on its way, minus the one leaving now, must leave room.
    assign credit_used = {1'b0, cnt} + {2'b00, inflight_reg} - {2'b00, pop};
    assign rd          = !reset && !empty && (credit_used < 3'(depth));

    always_ff @(posedge r_clk) begin
        if (reset) begin
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= rd;
        end
    end

    prefetch_skid_buf #(
        .data_size(data_size)
    ) u_skid_buf (
        .r_clk (r_clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (rd_data),
        .dout  (m_data),
        .cnt   (cnt),
        .valid (m_valid)
    );

`ifdef FIFO_PREFETCH_LEVEL_EN
    logic overrun_reg;

    assign level = level_add(cnt, inflight_reg);

    always_ff @(posedge r_clk) begin
        if (reset) begin
            overrun_reg <= 1'b0;
        end else if (push && !pop && (cnt == 2'd2)) begin
            overrun_reg <= 1'b1;
        end
    end

    assign overrun = overrun_reg;
`endif

endmodule

// File: doc/fifo_read_prefetch.md
Name: fifo_read_prefetch

Overview:
- Read-side stage directly downstream of the FIFO control unit/memory, in the r_clk domain.
- Converts the FIFO's rd/empty plus one-cycle-latency read-data interface into a registered valid/ready stream.
- Holds up to 2 words (head + skid), so the consumer sees full throughput and zero-bubble back-to-back transfers.

Parameters:
- data_size, 8, width of a FIFO word and of m_data.
- depth, 2, prefetch buffer entries; fixed at 2, any other value is a compile-time error.

Ports:
- r_clk  input  1  read-domain clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- empty  input  1  FIFO empty flag, r_clk domain.
- rd  output  1  read command to FIFO; pops one word when high and empty low.
- rd_data  input  data_size  FIFO read data, valid exactly 1 cycle after an accepted rd.
- m_valid  output  1  stream word available.
- m_ready  input  1  consumer accepts word.
- m_data  output  data_size  stream word (head entry).

Behaviour:
- State: cnt (0..2 stored words), inflight (1 bit, a read was issued last cycle), buf0 (head) and buf1 (skid).
- pop = m_valid & m_ready.
- rd = !reset & !empty & ((cnt + inflight - pop) < 2). This is a combinational path from m_ready and empty to rd; it is permitted.
- inflight <= rd, registered. When inflight is high, rd_data is captured that cycle.
- Capture, push without pop:
  - cnt 0: to buf0.
  - cnt 1: to buf1.
- Push with pop:
  - cnt 1: rd_data to buf0.
  - cnt 2: buf1 to buf0, rd_data to buf1.
- Pop without push:
  - cnt 2: buf1 to buf0.
  - cnt 1: buf0 unchanged, cnt goes to 0.
- cnt update: cnt <= cnt + push - pop. The push/pop logic never lets cnt exceed 2 or go below 0.
- m_valid = (cnt != 0), driven from a register. m_data = buf0, registered, with no combinational path from rd_data.
- Latency: the first word reaches m_valid 2 cycles after empty falls (cycle N rd, N+1 capture, N+1 edge end gives m_valid).
- Order is strictly preserved; no word is duplicated or dropped.
- Stream rule: once m_valid is high, m_data is held stable until pop.
- Reset (any cycle, including mid-transfer): cnt=0, inflight=0, buf0=buf1=0, m_valid=0, m_data=0, rd=0. A word in flight at reset is discarded. The FIFO pointers are reset by the same system reset.
- empty rising while inflight is high: the in-flight word is still captured, and no new rd is issued.
- m_ready high while m_valid is low: no effect.

Optional Feature:
- Macro: FIFO_PREFETCH_LEVEL_EN.
- Defined:
  - Adds output level, 2 bits, equal to cnt + inflight, registered-state derived, reset 0.
  - Adds output overrun, 1 bit, sticky. It sets if a capture would exceed 2 entries and clears only on reset.
- Undefined: neither port exists, and there is no related logic.

Decomposition:
- Shared package fifo_pkg:
  - Constant PREFETCH_DEPTH = 2.
  - Typedef for the level/count encoding (2-bit).
  - Shared data_size default.
- Sub-module prefetch_skid_buf:
  - Holds the 2-entry buf0/buf1 shift/load datapath and cnt.
  - Inputs: push, pop, din. Outputs: dout, cnt.
- The top level keeps the rd/inflight credit logic and the optional feature.

Test Plan:
- Reset then idle: reset high 3 cycles with empty=0 → rd=0, m_valid=0, m_data=0. After release, rd=1 in the first cycle.
- Single word: empty falls at cycle 10, FIFO returns 0xA5 at cycle 11, m_ready=1 → m_valid=1 with m_data=0xA5 from cycle 12, one pop, then m_valid=0 (empty=1 after the pop).
- Streaming: 16 words 0x00..0x0F queued, m_ready=1 constantly → after the 2-cycle start, m_valid stays high 16 consecutive cycles, data in order, rd high every cycle while non-empty.
- Backpressure: 4 words queued, m_ready=0 → exactly 2 rd pulses, cnt=2, m_data=0x00 held stable. Raise m_ready → 0x00, 0x01, 0x02, 0x03 delivered back-to-back with no loss.
- Random m_ready (50%) and random empty over 1000 words → output sequence matches input exactly, and rd is never high while empty=1.
- Reset mid-stream with cnt=2 and inflight=1 → next cycle m_valid=0, rd=0. With FIFO_PREFETCH_LEVEL_EN defined, level=0 and overrun=0.
